// File: rtl/axis_tm_frame_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : axis_tm_frame_ctrl                                          |
// | Description : AXI-Stream front/back end for the Tsetlin-machine inference |
// |               core. Slices each input frame into indexed packets, limits  |
// |               frames in flight with credits, buffers per-frame class sums |
// |               in a FIFO and serialises them onto the master stream.       |
// | Build macro : ARGMAX_EN - send one beat per frame holding the index of    |
// |               the largest signed class sum instead of the raw sums.       |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
// Ports:
//   clk, rst                      clock (posedge), asynchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast   feature packet input stream
//   core_x/core_valid/core_pkt_idx/core_last/core_abort   packets to the core
//   core_done/core_class_sums     per-frame result from the core (oldest frame)
//   m_axis_tdata/tvalid/tready/tlast/tkeep   result output stream
//   err_tlast, err_ovf            sticky error flags
module axis_tm_frame_ctrl #(
  parameter int S_TDATA_WIDTH = 64,
  parameter int M_TDATA_WIDTH = 64,
  parameter int FEATURE_NUM   = 784,
  parameter int PACKETS_NUM   = (FEATURE_NUM - 1) / S_TDATA_WIDTH + 1,
  parameter int CLASS_NUM     = 10,
  parameter int WEIGHT_LENGTH = 6,
  parameter int RES_DEPTH     = 4,
  localparam int RES_BITS     = CLASS_NUM * WEIGHT_LENGTH,
  localparam int IDX_W        = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [S_TDATA_WIDTH-1:0]   core_x,
  output logic                       core_valid,
  output logic [IDX_W-1:0]           core_pkt_idx,
  output logic                       core_last,
  output logic                       core_abort,
  input  logic                       core_done,
  input  logic [RES_BITS-1:0]        core_class_sums,
  output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                       err_tlast,
  output logic                       err_ovf
);

  localparam int KEEP_W = M_TDATA_WIDTH / 8;
  localparam int CIDX_W = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
`ifdef ARGMAX_EN
  localparam int ENTRY_W   = CIDX_W;
  localparam int OUT_BEATS = 1;
`else
  localparam int ENTRY_W    = RES_BITS;
  localparam int OUT_BEATS  = (RES_BITS + M_TDATA_WIDTH - 1) / M_TDATA_WIDTH;
  localparam int LAST_BYTES = (RES_BITS - (OUT_BEATS - 1) * M_TDATA_WIDTH + 7) / 8;
`endif
  localparam int BEAT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RES_DEPTH + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PACKETS_NUM - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RES_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RES_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(OUT_BEATS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------- state
  logic [IDX_W-1:0]         pkt_idx_q, pkt_idx_d;
  logic [CNT_W-1:0]         occ_q, occ_d;
  logic [S_TDATA_WIDTH-1:0] core_x_q, core_x_d;
  logic                     core_valid_q, core_valid_d;
  logic [IDX_W-1:0]         core_pkt_idx_q, core_pkt_idx_d;
  logic                     core_last_q, core_last_d;
  logic                     core_abort_q, core_abort_d;
  logic                     err_tlast_q, err_tlast_d;
  logic                     err_ovf_q, err_ovf_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;

  logic [ENTRY_W-1:0]       fifo_mem [RES_DEPTH];

  logic               in_hs, at_last, early_last, fwd, issue;
  logic               out_hs, pop, push_ok;
  logic [ENTRY_W-1:0] push_data, head;

  // A frame that has started (pkt_idx != 0) always keeps its credit.
  assign s_axis_tready = !rst && ((pkt_idx_q != '0) || (occ_q < DEPTH_C));

  assign in_hs      = s_axis_tvalid & s_axis_tready;
  assign at_last    = (pkt_idx_q == LAST_IDX);
  assign early_last = in_hs & s_axis_tlast & !at_last;
  assign fwd        = in_hs & !early_last;
  assign issue      = fwd & at_last;

  assign out_hs  = m_axis_tvalid & m_axis_tready;
  assign pop     = out_hs & (beat_q == LAST_BEAT);
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok = core_done & ((cnt_q != DEPTH_C) | pop);
  assign head    = fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------- input side
  always_comb begin
    pkt_idx_d      = pkt_idx_q;
    core_x_d       = core_x_q;
    core_pkt_idx_d = core_pkt_idx_q;
    core_valid_d   = fwd;
    core_last_d    = issue;
    core_abort_d   = early_last;
    err_tlast_d    = err_tlast_q | early_last | (in_hs & at_last & !s_axis_tlast);
    if (fwd) begin
      core_x_d       = s_axis_tdata;
      core_pkt_idx_d = pkt_idx_q;
      pkt_idx_d      = at_last ? '0 : pkt_idx_q + 1'b1;
    end
    if (early_last) begin
      pkt_idx_d = '0;
    end
  end

  // Frames in flight: counted from issue to the final output handshake.
  always_comb begin
    occ_d = occ_q;
    case ({issue, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------- result FIFO
`ifdef ARGMAX_EN
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    logic signed [WEIGHT_LENGTH-1:0] best;
    logic [CIDX_W-1:0]               best_idx;
    best     = core_class_sums[WEIGHT_LENGTH-1:0];
    best_idx = '0;
    for (int c = 1; c < CLASS_NUM; c++) begin
      if ($signed(core_class_sums[c*WEIGHT_LENGTH +: WEIGHT_LENGTH]) > best) begin
        best     = core_class_sums[c*WEIGHT_LENGTH +: WEIGHT_LENGTH];
        best_idx = CIDX_W'(c);
      end
    end
    push_data = best_idx;
  end
`else
  assign push_data = core_class_sums;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q | (core_done & !push_ok);
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  // ---------------------------------------------------------- output FSM
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (cnt_q != '0) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            // Stay in SEND when another result is already queued.
            state_d = (cnt_d != '0) ? ST_SEND : ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign m_axis_tvalid = (state_q == ST_SEND);

`ifdef ARGMAX_EN
  always_comb begin
    m_axis_tdata = '0;
    if (m_axis_tvalid) begin
      m_axis_tdata[CIDX_W-1:0] = head;
    end
    m_axis_tkeep = m_axis_tvalid ? {KEEP_W{1'b1}} : '0;
    m_axis_tlast = m_axis_tvalid;
  end
`else
  always_comb begin
    logic [OUT_BEATS*M_TDATA_WIDTH-1:0] padded;
    logic                               is_last;
    padded                 = '0;
    padded[RES_BITS-1:0]   = head;
    is_last                = (beat_q == LAST_BEAT);
    m_axis_tdata = m_axis_tvalid ? padded[int'(beat_q)*M_TDATA_WIDTH +: M_TDATA_WIDTH] : '0;
    m_axis_tlast = m_axis_tvalid & is_last;
    for (int i = 0; i < KEEP_W; i++) begin
      m_axis_tkeep[i] = m_axis_tvalid & (!is_last | (i < LAST_BYTES));
    end
  end
`endif

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_idx_q      <= '0;
      occ_q          <= '0;
      core_x_q       <= '0;
      core_valid_q   <= 1'b0;
      core_pkt_idx_q <= '0;
      core_last_q    <= 1'b0;
      core_abort_q   <= 1'b0;
      err_tlast_q    <= 1'b0;
      err_ovf_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      state_q        <= ST_IDLE;
      beat_q         <= '0;
    end else begin
      pkt_idx_q      <= pkt_idx_d;
      occ_q          <= occ_d;
      core_x_q       <= core_x_d;
      core_valid_q   <= core_valid_d;
      core_pkt_idx_q <= core_pkt_idx_d;
      core_last_q    <= core_last_d;
      core_abort_q   <= core_abort_d;
      err_tlast_q    <= err_tlast_d;
      err_ovf_q      <= err_ovf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      beat_q         <= beat_d;
    end
  end

  assign core_x       = core_x_q;
  assign core_valid   = core_valid_q;
  assign core_pkt_idx = core_pkt_idx_q;
  assign core_last    = core_last_q;
  assign core_abort   = core_abort_q;
  assign err_tlast    = err_tlast_q;
  assign err_ovf      = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_tm_frame_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_axis_tm_frame_ctrl                                       |
// | Description : Directed self-checking bench for axis_tm_frame_ctrl with    |
// |               12 classes of 8-bit sums (two 64-bit result beats, or one   |
// |               argmax beat when ARGMAX_EN is defined).                     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_axis_tm_frame_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] core_x;
  logic        core_valid;
  logic [3:0]  core_pkt_idx;
  logic        core_last;
  logic        core_abort;
  logic        core_done;
  logic [95:0] core_class_sums;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;
  logic        err_tlast;
  logic        err_ovf;

  int total = 0;
  int bad   = 0;

  // Class c sits in byte c (class 0 in the low byte); amax noted by hand.
  localparam logic [95:0] V0 = 96'h040102F9_00068005_0707FE03; // {3,-2,7,7,..} -> 2
  localparam logic [95:0] V1 = 96'hFAFAF9F8_F7F6F5F4_F3F2F1F0; // tie at 10,11  -> 10
  localparam logic [95:0] V2 = 96'h7F000000_00000000_00000000; // -> 11
  localparam logic [95:0] V3 = 96'h7E7E7E7E_7E7E7E7E_7E7E7E7F; // -> 0
  localparam logic [95:0] V4 = 96'h11223344_55667788_99AABBCC; // signed max 0x77 -> 5
  localparam logic [95:0] V5 = 96'h00010001_00000000_80808080; // tie at 8,10 -> 8
  localparam logic [95:0] V6 = 96'hDEADBEEF_CAFEF00D_12345678; // dropped on overflow
  localparam logic [95:0] V7 = 96'h00000000_00000000_00000000; // dropped by reset

  axis_tm_frame_ctrl #(
    .CLASS_NUM     (12),
    .WEIGHT_LENGTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .core_x          (core_x),
    .core_valid      (core_valid),
    .core_pkt_idx    (core_pkt_idx),
    .core_last       (core_last),
    .core_abort      (core_abort),
    .core_done       (core_done),
    .core_class_sums (core_class_sums),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tkeep    (m_axis_tkeep),
    .err_tlast       (err_tlast),
    .err_ovf         (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One input beat; checks what the core sees right after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input bit last, input int exp_idx,
                           input bit exp_fwd);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("in_timeout", s_axis_tready, 1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (exp_fwd) begin
      chk("core_beat", {core_valid, core_last, core_pkt_idx, core_x},
          {1'b1, (exp_idx == 12), 4'(exp_idx), d});
      chk("core_abort_lo", core_abort, 0);
    end else begin
      chk("core_valid_lo", core_valid, 0);
      chk("core_abort", core_abort, 1);
    end
  endtask

  task automatic send_frame(input bit tlast_ok);
    logic [63:0] d;
    for (int i = 0; i < 13; i++) begin
      d = {$urandom(), $urandom()};
      send_beat(d, (i == 12) && tlast_ok, i, 1'b1);
    end
  endtask

  task automatic pulse_done(input logic [95:0] v);
    core_class_sums = v;
    core_done       = 1'b1;
    @(posedge clk); #1;
    core_done       = 1'b0;
  endtask

  // Receives one result; stalls with tready low and checks the beat holds.
  task automatic recv_result(input logic [95:0] v, input int amax, input bit b2b);
    int nb;
`ifdef ARGMAX_EN
    nb = 1;
`else
    nb = 2;
`endif
    for (int b = 0; b < nb; b++) begin
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el;
      int          n;
      int          st;
`ifdef ARGMAX_EN
      ed = 64'(amax);
      ek = 8'hFF;
      el = 1'b1;
`else
      if (b == 0) begin
        ed = v[63:0];
        ek = 8'hFF;
        el = 1'b0;
      end else begin
        ed = {32'h0, v[95:64]};
        ek = 8'h0F;
        el = 1'b1;
      end
`endif
      if (b2b && b == 0) chk("b2b_valid", m_axis_tvalid, 1);
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 20) begin
        chk("out_timeout", m_axis_tvalid, 1);
        return;
      end
      chk($sformatf("res%0d_beat%0d", amax, b), {m_axis_tlast, m_axis_tkeep, m_axis_tdata},
          {el, ek, ed});
      st = b2b ? 0 : 1 + $urandom_range(0, 1);
      repeat (st) begin
        @(posedge clk); #1;
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
            {1'b1, el, ek, ed});
      end
      m_axis_tready = 1'b1;
      @(posedge clk); #1;
      m_axis_tready = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [63:0] d;
    rst             = 1'b1;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    core_done       = 1'b0;
    core_class_sums = '0;
    m_axis_tready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_outs", {core_valid, core_abort, core_last, err_tlast, err_ovf,
                     m_axis_tlast, m_axis_tkeep, m_axis_tdata, core_x}, 0);
    rst = 1'b0;
    #1;
    chk("idle_s_tready", s_axis_tready, 1);

    // One frame, one result of two beats
    send_frame(1'b1);
    chk("no_err_tlast", err_tlast, 0);
    chk("no_result_yet", m_axis_tvalid, 0);
    pulse_done(V0);
    recv_result(V0, 2, 1'b0);
    chk("idle_after_drain", m_axis_tvalid, 0);
    chk("credit_free", s_axis_tready, 1);

    // Credit: four frames in flight block the fifth
    repeat (4) send_frame(1'b1);
    chk("credit_stall", s_axis_tready, 0);
    s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("credit_hold", {s_axis_tready, core_valid}, 2'b00);
    end
    s_axis_tvalid = 1'b0;
    pulse_done(V1);
    recv_result(V1, 10, 1'b0);
    chk("credit_release", s_axis_tready, 1);

    // Fill the FIFO, overflow once, drain back-to-back
    send_frame(1'b1);
    pulse_done(V2);
    pulse_done(V3);
    pulse_done(V4);
    pulse_done(V5);
    chk("no_ovf", err_ovf, 0);
    pulse_done(V6);
    chk("ovf_set", err_ovf, 1);
    recv_result(V2, 11, 1'b0);
    recv_result(V3, 0, 1'b1);
    recv_result(V4, 5, 1'b1);
    recv_result(V5, 8, 1'b1);
    chk("ovf_dropped", m_axis_tvalid, 0);
    chk("credit_all_free", s_axis_tready, 1);

    // Early tlast on packet index 5
    for (int i = 0; i < 5; i++) begin
      d = {$urandom(), $urandom()};
      send_beat(d, 1'b0, i, 1'b1);
    end
    send_beat(64'h5555_AAAA_5555_AAAA, 1'b1, 5, 1'b0);
    chk("err_tlast_early", err_tlast, 1);
    @(posedge clk); #1;
    chk("abort_one_pulse", core_abort, 0);
    send_frame(1'b1);

    // Reset while a result is on the master stream
    pulse_done(V7);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", m_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_kills_tvalid", m_axis_tvalid, 0);
    chk("rst_kills_tready", s_axis_tready, 0);
    chk("rst_clears_err", {err_tlast, err_ovf}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_tready", s_axis_tready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_fifo_empty", m_axis_tvalid, 0);

    // Missing tlast, then occupancy restarted from zero
    send_frame(1'b0);
    chk("err_tlast_missing", err_tlast, 1);
    repeat (3) send_frame(1'b1);
    chk("post_rst_credit", s_axis_tready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
